// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Each operation is accepted in IDLE, issued to the ALU in ISSUE, and held
// in RESP until the granted requester consumes the result.
// The priority pointer alternates between requesters so that neither starves.
module alu_share_arbiter #(
  parameter int unsigned REGISTER_LEN        = 32,
  parameter int unsigned EXECUTE_COMMAND_LEN = 4
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic                           req0_valid,
  output logic                           req0_ready,
  input  logic [REGISTER_LEN-1:0]        req0_in1,
  input  logic [REGISTER_LEN-1:0]        req0_in2,
  input  logic [EXECUTE_COMMAND_LEN-1:0] req0_cmd,
  input  logic                           req0_cin,

  input  logic                           req1_valid,
  output logic                           req1_ready,
  input  logic [REGISTER_LEN-1:0]        req1_in1,
  input  logic [REGISTER_LEN-1:0]        req1_in2,
  input  logic [EXECUTE_COMMAND_LEN-1:0] req1_cmd,
  input  logic                           req1_cin,

  output logic                           rsp0_valid,
  input  logic                           rsp0_ready,
  output logic [REGISTER_LEN-1:0]        rsp0_result,
  output logic [3:0]                     rsp0_status,

  output logic                           rsp1_valid,
  input  logic                           rsp1_ready,
  output logic [REGISTER_LEN-1:0]        rsp1_result,
  output logic [3:0]                     rsp1_status,

  output logic [REGISTER_LEN-1:0]        alu_in1,
  output logic [REGISTER_LEN-1:0]        alu_in2,
  output logic [EXECUTE_COMMAND_LEN-1:0] alu_command,
  output logic                           alu_cin,
  input  logic [REGISTER_LEN-1:0]        alu_out,
  input  logic [3:0]                     alu_status
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_t;

  state_t                         state_q, state_d;
  logic                           ptr_q, ptr_d;   // 0: req0 wins a tie, 1: req1 wins
  logic                           gnt_q, gnt_d;   // requester owning the in-flight op
  logic [REGISTER_LEN-1:0]        in1_q, in1_d;
  logic [REGISTER_LEN-1:0]        in2_q, in2_d;
  logic [EXECUTE_COMMAND_LEN-1:0] cmd_q, cmd_d;
  logic                           cin_q, cin_d;
  logic [REGISTER_LEN-1:0]        result_q, result_d;
  logic [3:0]                     status_q, status_d;

  logic any_valid;
  logic gnt_sel;
  logic rsp_ready_g;

  // Grant selection: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    any_valid   = req0_valid | req1_valid;
    gnt_sel     = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    rsp_ready_g = gnt_q ? rsp1_ready : rsp0_ready;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      cmd_q    <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      cmd_q    <= cmd_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  // Next-state, operand capture and handshake outputs.
  // Ready is also qualified by rst so nothing appears accepted while reset is held.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    cmd_d      = cmd_q;
    cin_d      = cin_q;
    result_d   = result_q;
    status_d   = status_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_valid && rst) begin
          req0_ready = ~gnt_sel;
          req1_ready = gnt_sel;
          gnt_d      = gnt_sel;
          ptr_d      = ~gnt_sel;
          in1_d      = gnt_sel ? req1_in1 : req0_in1;
          in2_d      = gnt_sel ? req1_in2 : req0_in2;
          cmd_d      = gnt_sel ? req1_cmd : req0_cmd;
          cin_d      = gnt_sel ? req1_cin : req0_cin;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        result_d = alu_out;
        status_d = alu_status;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid = ~gnt_q;
        rsp1_valid = gnt_q;
        if (rsp_ready_g) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The ALU always sees the last registered operation; it only matters in ISSUE.
  always_comb begin
    alu_in1     = in1_q;
    alu_in2     = in2_q;
    alu_command = cmd_q;
    alu_cin     = cin_q;
    rsp0_result = result_q;
    rsp0_status = status_q;
    rsp1_result = result_q;
    rsp1_status = status_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small combinational ALU model.
module tb_alu_share_arbiter;

  localparam int unsigned RL = 32;
  localparam int unsigned CL = 4;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_ADC = 4'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_cin;
  logic [RL-1:0] req0_in1, req0_in2;
  logic [CL-1:0] req0_cmd;
  logic          req1_valid, req1_ready, req1_cin;
  logic [RL-1:0] req1_in1, req1_in2;
  logic [CL-1:0] req1_cmd;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [RL-1:0] rsp0_result, rsp1_result;
  logic [3:0]    rsp0_status, rsp1_status;
  logic [RL-1:0] alu_in1, alu_in2, alu_out;
  logic [CL-1:0] alu_command;
  logic          alu_cin;
  logic [3:0]    alu_status;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .REGISTER_LEN       (RL),
    .EXECUTE_COMMAND_LEN(CL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req0_cmd   (req0_cmd),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .req1_cmd   (req1_cmd),
    .req1_cin   (req1_cin),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_result(rsp0_result),
    .rsp0_status(rsp0_status),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_result(rsp1_result),
    .rsp1_status(rsp1_status),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_command(alu_command),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_status (alu_status)
  );

  // Shared ALU model, flags ordered {Z,C,N,V}; C is carry-out (no-borrow on SUB).
  logic [RL:0] wide;
  logic        ovf;
  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    case (alu_command)
      CMD_ADD: begin
        wide = {1'b0, alu_in1} + {1'b0, alu_in2};
        ovf  = (alu_in1[RL-1] == alu_in2[RL-1]) && (wide[RL-1] != alu_in1[RL-1]);
      end
      CMD_SUB: begin
        wide = {1'b0, alu_in1} + {1'b0, ~alu_in2} + 33'd1;
        ovf  = (alu_in1[RL-1] != alu_in2[RL-1]) && (wide[RL-1] != alu_in1[RL-1]);
      end
      CMD_ADC: begin
        wide = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'd0, alu_cin};
        ovf  = (alu_in1[RL-1] == alu_in2[RL-1]) && (wide[RL-1] != alu_in1[RL-1]);
      end
      default: begin
        wide = '0;
        ovf  = 1'b0;
      end
    endcase
    alu_out    = wide[RL-1:0];
    alu_status = {(wide[RL-1:0] == '0), wide[RL], wide[RL-1], ovf};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic ci);
    req0_valid = v; req0_in1 = a; req0_in2 = b; req0_cmd = c; req0_cin = ci;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic ci);
    req1_valid = v; req1_in1 = a; req1_in2 = b; req1_cmd = c; req1_cin = ci;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set_req0(1'b1, 32'd9, 32'd9, CMD_ADD, 1'b1);
    set_req1(1'b1, 32'd9, 32'd9, CMD_ADD, 1'b1);

    // Reset values with both requesters asserting
    nxt(); nxt(); #1;
    check("rst_req0_ready", 32'(req0_ready), 0);
    check("rst_req1_ready", 32'(req1_ready), 0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_in2", alu_in2, 0);
    check("rst_alu_cmd", 32'(alu_command), 0);
    check("rst_alu_cin", 32'(alu_cin), 0);
    check("rst_rsp0_result", rsp0_result, 0);
    check("rst_rsp1_status", 32'(rsp1_status), 0);

    // req0 only: ADD 5+7, accepted on the first edge after release
    nxt();
    rst = 1'b1;
    set_req1(1'b0, 32'd0, 32'd0, CMD_ADD, 1'b0);
    set_req0(1'b1, 32'd5, 32'd7, CMD_ADD, 1'b0);
    #1;
    check("add_req0_ready", 32'(req0_ready), 1);
    check("add_req1_ready", 32'(req1_ready), 0);
    nxt();
    set_req0(1'b0, 32'd99, 32'd99, CMD_SUB, 1'b1);
    #1;
    check("add_issue_ready", 32'(req0_ready), 0);
    check("add_issue_rsp0_valid", 32'(rsp0_valid), 0);
    check("add_alu_in1", alu_in1, 5);
    check("add_alu_in2", alu_in2, 7);
    check("add_alu_cmd", 32'(alu_command), 32'(CMD_ADD));
    nxt(); #1;
    check("add_rsp0_valid", 32'(rsp0_valid), 1);
    check("add_rsp1_valid", 32'(rsp1_valid), 0);
    check("add_result", rsp0_result, 12);
    check("add_status", 32'(rsp0_status), 32'h0);
    rsp0_ready = 1'b1;
    nxt();
    rsp0_ready = 1'b0;
    #1;
    check("add_done_rsp0_valid", 32'(rsp0_valid), 0);

    // Fresh reset, then both valid: req0 first, req1 three cycles later
    nxt(); rst = 1'b0;
    nxt(); rst = 1'b1;
    set_req0(1'b1, 32'd3, 32'd3, CMD_SUB, 1'b0);
    set_req1(1'b1, 32'd1, 32'd1, CMD_ADD, 1'b0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    check("both_c0_req0_ready", 32'(req0_ready), 1);
    check("both_c0_req1_ready", 32'(req1_ready), 0);
    nxt();
    req0_valid = 1'b0;
    #1;
    check("both_c1_req1_ready", 32'(req1_ready), 0);
    nxt(); #1;
    check("both_c2_rsp0_valid", 32'(rsp0_valid), 1);
    check("both_c2_rsp1_valid", 32'(rsp1_valid), 0);
    check("sub_result", rsp0_result, 0);
    check("sub_status", 32'(rsp0_status), 32'hC);
    nxt(); #1;
    check("both_c3_req1_ready", 32'(req1_ready), 1);
    check("both_c3_req0_ready", 32'(req0_ready), 0);
    nxt();
    req1_valid = 1'b0;
    nxt(); #1;
    check("both_c5_rsp1_valid", 32'(rsp1_valid), 1);
    check("add11_result", rsp1_result, 2);
    check("add11_status", 32'(rsp1_status), 32'h0);

    // Continuous contention: grants alternate starting with req0
    nxt();
    set_req0(1'b1, 32'd100, 32'd1, CMD_ADD, 1'b0);
    set_req1(1'b1, 32'd200, 32'd2, CMD_ADD, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("alt%0d_grant", i), 32'({req1_ready, req0_ready}), (i % 2 != 0) ? 2 : 1);
      nxt(); nxt(); #1;
      check($sformatf("alt%0d_rsp_valid", i), 32'({rsp1_valid, rsp0_valid}), (i % 2 != 0) ? 2 : 1);
      check($sformatf("alt%0d_result", i), (i % 2 != 0) ? rsp1_result : rsp0_result,
            (i % 2 != 0) ? 202 : 101);
      nxt();
    end

    // req1 alone, then its response is back-pressured while req0 waits
    req0_valid = 1'b0;
    set_req1(1'b1, 32'h7FFF_FFFF, 32'd1, CMD_ADD, 1'b0);
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    #1;
    check("bp_req1_ready", 32'(req1_ready), 1);
    nxt();
    set_req0(1'b1, 32'hFFFF_FFFF, 32'd0, CMD_ADC, 1'b1);
    set_req1(1'b0, 32'd0, 32'd0, CMD_SUB, 1'b1);
    #1;
    check("bp_issue_req0_ready", 32'(req0_ready), 0);
    for (int k = 0; k < 5; k++) begin
      nxt(); #1;
      check($sformatf("bp%0d_rsp1_valid", k), 32'(rsp1_valid), 1);
      check($sformatf("bp%0d_result", k), rsp1_result, 32'h8000_0000);
      check($sformatf("bp%0d_status", k), 32'(rsp1_status), 32'h3);
      check($sformatf("bp%0d_req0_ready", k), 32'(req0_ready), 0);
      check($sformatf("bp%0d_rsp0_valid", k), 32'(rsp0_valid), 0);
    end
    nxt();
    rsp1_ready = 1'b1;
    #1;
    check("bp_release_rsp1_valid", 32'(rsp1_valid), 1);
    check("bp_release_req0_ready", 32'(req0_ready), 0);
    nxt();
    rsp1_ready = 1'b0;
    #1;
    check("pend_req0_ready", 32'(req0_ready), 1);
    check("pend_rsp1_valid", 32'(rsp1_valid), 0);

    // ADC all-ones + 0 + carry wraps to zero with carry out
    nxt();
    req0_valid = 1'b0;
    #1;
    check("adc_alu_in1", alu_in1, 32'hFFFF_FFFF);
    check("adc_alu_cin", 32'(alu_cin), 1);
    nxt(); #1;
    check("adc_rsp0_valid", 32'(rsp0_valid), 1);
    check("adc_result", rsp0_result, 0);
    check("adc_status", 32'(rsp0_status), 32'hC);

    // Reset during ISSUE aborts the operation and clears the pointer
    nxt();
    set_req0(1'b1, 32'd5, 32'd7, CMD_ADD, 1'b0);
    #1;
    check("abort_req0_ready", 32'(req0_ready), 1);
    nxt();
    req0_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_rsp0_valid", 32'(rsp0_valid), 0);
    check("abort_rsp1_valid", 32'(rsp1_valid), 0);
    check("abort_alu_in1", alu_in1, 0);
    check("abort_rsp0_result", rsp0_result, 0);
    nxt();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nxt(); #1;
      check($sformatf("post_abort%0d_rsp", k), 32'({rsp1_valid, rsp0_valid}), 0);
    end
    nxt();
    set_req0(1'b1, 32'd1, 32'd2, CMD_ADD, 1'b0);
    set_req1(1'b1, 32'd3, 32'd4, CMD_ADD, 1'b0);
    #1;
    check("post_abort_grant", 32'({req1_ready, req0_ready}), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
